// File: rtl/rc_poly_resampler.sv
// Rational L/M sample-rate converter: polyphase FIR with a loadable coefficient
// bank, one time-multiplexed MAC and valid/ready streams on input and output.
module rc_poly_resampler #(
  parameter int W     = 8,
  parameter int CW    = 9,
  parameter int OW    = 9,
  parameter int L     = 3,
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int SHIFT = 8,
  parameter int AW    = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic signed [W-1:0]                  x_in,
  input  logic                                 x_valid,
  output logic                                 x_ready,
  output logic signed [OW-1:0]                 y_out,
  output logic                                 y_valid,
  input  logic                                 y_ready,
  input  logic                                 c_we,
  input  logic [AW-1:0]                        c_addr,
  input  logic signed [CW-1:0]                 c_data,
  output logic [((L > 1) ? $clog2(L) : 1)-1:0] phase_o,
  output logic                                 sat_o
);
  localparam int PHW = (L > 1) ? $clog2(L) : 1;
  localparam int JW  = $clog2(N);
  localparam int ACW = W + CW + $clog2(N);
  localparam int PAW = $clog2(L + M + 1);
  localparam int NC  = 1 << AW;
  localparam logic signed [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {S_FILL, S_MAC, S_OUT} state_t;

  state_t                state_reg, state_next;
  logic [PAW-1:0]        ph_acc_reg;
  logic [PHW-1:0]        ph_reg;
  logic [JW-1:0]         j_reg;
  logic signed [ACW-1:0] acc_reg;
  logic signed [W-1:0]   taps [0:N-1];
  logic signed [CW-1:0]  coef_mem [0:NC-1];
  logic [NC-1:0]         c_wsel;

  logic                  x_accept;
  logic [AW-1:0]         rd_addr;
  logic signed [CW-1:0]  coef_sel;
  logic signed [W-1:0]   tap_sel;
  logic signed [ACW-1:0] prod, acc_base, acc_next, acc_shift;
  logic                  sat_hi, sat_lo;
  logic signed [OW-1:0]  y_sat;

  // Writes beyond the populated phase*N+tap range are dropped.
  generate
    for (genvar gi = 0; gi < NC; gi++) begin : g_wsel
      assign c_wsel[gi] = c_we && (c_addr == AW'(gi)) && (gi < L * N);
    end
  endgenerate

  assign x_accept = x_valid & x_ready;
  assign y_valid  = (state_reg == S_OUT);

  always_comb begin
    state_next = state_reg;
    x_ready    = 1'b0;
    case (state_reg)
      S_FILL: begin
        if (ph_acc_reg >= PAW'(L)) x_ready = 1'b1;
        else                       state_next = S_MAC;
      end
      S_MAC:   if (j_reg == JW'(N - 1)) state_next = S_OUT;
      S_OUT:   if (y_ready) state_next = S_FILL;
      default: state_next = S_FILL;
    endcase
  end

  always_comb begin
    rd_addr   = AW'(ph_reg) * AW'(N) + AW'(j_reg);
    coef_sel  = coef_mem[rd_addr];
    tap_sel   = taps[j_reg];
    prod      = ACW'(coef_sel) * ACW'(tap_sel);
    acc_base  = acc_reg;
    if (j_reg == '0) acc_base = '0;
    acc_next  = acc_base + prod;
    acc_shift = acc_next >>> SHIFT;
    sat_hi    = acc_shift > ACW'(OMAX);
    sat_lo    = acc_shift < ACW'(OMIN);
    y_sat     = acc_shift[OW-1:0];
    if (sat_hi) y_sat = OMAX;
    if (sat_lo) y_sat = OMIN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_FILL;
      ph_acc_reg <= PAW'(L);
      ph_reg     <= '0;
      j_reg      <= '0;
      acc_reg    <= '0;
      y_out      <= '0;
      phase_o    <= '0;
      sat_o      <= 1'b0;
      for (int i = 0; i < N; i++)  taps[i]     <= '0;
      for (int i = 0; i < NC; i++) coef_mem[i] <= '0;
    end else begin
      state_reg <= state_next;
      sat_o     <= 1'b0;
      for (int i = 0; i < NC; i++) begin
        if (c_wsel[i]) coef_mem[i] <= c_data;
      end
      if (x_accept) begin
        taps[0] <= x_in;
        for (int i = 1; i < N; i++) taps[i] <= taps[i-1];
      end
      case (state_reg)
        S_FILL: begin
          if (ph_acc_reg >= PAW'(L)) begin
            if (x_accept) ph_acc_reg <= ph_acc_reg - PAW'(L);
          end else begin
            ph_reg <= PHW'(ph_acc_reg);
            j_reg  <= '0;
          end
        end
        S_MAC: begin
          acc_reg <= acc_next;
          j_reg   <= j_reg + JW'(1);
          // The final product is folded straight into the output register.
          if (j_reg == JW'(N - 1)) begin
            y_out   <= y_sat;
            phase_o <= ph_reg;
            sat_o   <= sat_hi | sat_lo;
          end
        end
        S_OUT: begin
          if (y_ready) ph_acc_reg <= PAW'(ph_reg) + PAW'(M);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rc_poly_resampler.sv
// Directed self-checking bench for rc_poly_resampler: default 3/4 instance plus
// a 4/1 upsampling instance with two taps per phase.
module tb_rc_poly_resampler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic signed [7:0] x_in;
  logic              x_valid, x_ready;
  logic signed [8:0] y_out;
  logic              y_valid, y_ready;
  logic              c_we;
  logic [3:0]        c_addr;
  logic signed [8:0] c_data;
  logic [1:0]        phase_o;
  logic              sat_o;

  logic signed [7:0] x_in_u;
  logic              x_valid_u, x_ready_u;
  logic signed [8:0] y_out_u;
  logic              y_valid_u, y_ready_u;
  logic              c_we_u;
  logic [2:0]        c_addr_u;
  logic signed [8:0] c_data_u;
  logic [1:0]        phase_u;
  logic              sat_u;

  int checks = 0;
  int errors = 0;

  rc_poly_resampler dut (
    .clk(clk), .reset(reset),
    .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready),
    .c_we(c_we), .c_addr(c_addr), .c_data(c_data),
    .phase_o(phase_o), .sat_o(sat_o)
  );

  rc_poly_resampler #(.L(4), .M(1), .N(2), .AW(3)) dut_up (
    .clk(clk), .reset(reset),
    .x_in(x_in_u), .x_valid(x_valid_u), .x_ready(x_ready_u),
    .y_out(y_out_u), .y_valid(y_valid_u), .y_ready(y_ready_u),
    .c_we(c_we_u), .c_addr(c_addr_u), .c_data(c_data_u),
    .phase_o(phase_u), .sat_o(sat_u)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    x_valid = 0; y_ready = 1; c_we = 0;
    x_valid_u = 0; y_ready_u = 1; c_we_u = 0;
    reset = 0;
    #2;
    tick();
    reset = 1;
    tick();
  endtask

  task automatic write_coef(input int a, input int d);
    c_we = 1; c_addr = 4'(a); c_data = 9'(d);
    tick();
    c_we = 0;
  endtask

  task automatic write_coef_u(input int a, input int d);
    c_we_u = 1; c_addr_u = 3'(a); c_data_u = 9'(d);
    tick();
    c_we_u = 0;
  endtask

  // Streams xv with y_ready=1 until one output transfers.
  task automatic step_out(input logic signed [7:0] xv, output logic signed [8:0] yv,
                          output logic [1:0] pv, output logic sv, output int nin,
                          output int lat, output bit ok);
    int last_acc;
    last_acc = 0; yv = '0; pv = '0; sv = 0; nin = 0; lat = 0; ok = 0;
    x_in = xv; x_valid = 1; y_ready = 1;
    for (int c = 0; c < 60; c++) begin
      if (y_valid) begin
        yv = y_out; pv = phase_o; sv = sat_o; lat = c - last_acc; ok = 1;
        break;
      end
      if (x_ready) begin
        nin++;
        last_acc = c;
      end
      tick();
    end
    if (ok) tick();
    x_valid = 0;
    $display("out y=%0d phase=%0d sat=%0d inputs=%0d ok=%0d", yv, pv, sv, nin, ok);
  endtask

  task automatic test_reset();
    x_in = 0; x_valid = 0; y_ready = 1; c_we = 0; c_addr = 0; c_data = 0;
    x_in_u = 0; x_valid_u = 0; y_ready_u = 1; c_we_u = 0; c_addr_u = 0; c_data_u = 0;
    reset = 1;
    #2;
    reset = 0;
    #2;
    checks++;
    if (y_valid !== 1'b0 || y_out !== 9'sd0 || sat_o !== 1'b0 || phase_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: y_valid=%b y_out=%0d sat=%b phase=%0d, required 0 0 0 0",
               y_valid, y_out, sat_o, phase_o);
    end
    checks++;
    if (x_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_x_ready: got %b, required 1", x_ready);
    end
    checks++;
    if (y_valid_u !== 1'b0 || x_ready_u !== 1'b1) begin
      errors++;
      $display("FAIL reset_up: y_valid=%b x_ready=%b, required 0 1", y_valid_u, x_ready_u);
    end
    tick();
    reset = 1;
    tick();
  endtask

  task automatic test_phase_sequence();
    int exp_ph[7] = '{0, 1, 2, 0, 1, 2, 0};
    int exp_n[7]  = '{1, 1, 1, 2, 1, 1, 2};
    logic signed [8:0] y;
    logic [1:0] p;
    logic s;
    int n, lat, total;
    bit ok;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      step_out(8'sd1, y, p, s, n, lat, ok);
      checks++;
      if (!ok || p !== 2'(exp_ph[k]) || n != exp_n[k] || y !== 9'sd0) begin
        errors++;
        $display("FAIL phase_seq[%0d]: ok=%0d phase=%0d inputs=%0d y=%0d, required phase=%0d inputs=%0d y=0",
                 k, ok, p, n, y, exp_ph[k], exp_n[k]);
      end
      if (k == 0) begin
        checks++;
        if (lat != 6) begin
          errors++;
          $display("FAIL latency: got %0d cycles, required 6", lat);
        end
      end
    end
    total = 0;
    for (int k = 0; k < 12; k++) begin
      step_out(8'sd1, y, p, s, n, lat, ok);
      total += n;
    end
    checks++;
    if (total != 16) begin
      errors++;
      $display("FAIL long_run_ratio: %0d inputs for 12 outputs, required 16", total);
    end
  endtask

  task automatic test_dc_gain();
    int exp_y[7] = '{4, 16, 36, 16, 32, 48, 16};
    logic signed [8:0] y;
    logic [1:0] p;
    logic s;
    int n, lat;
    bit ok;
    do_reset();
    for (int ph = 0; ph < 3; ph++)
      for (int j = 0; j < 4; j++) write_coef(ph * 4 + j, 16 * (ph + 1));
    for (int k = 0; k < 7; k++) begin
      step_out(8'sd64, y, p, s, n, lat, ok);
      checks++;
      if (!ok || y !== 9'(exp_y[k]) || s !== 1'b0) begin
        errors++;
        $display("FAIL dc_gain[%0d]: y=%0d sat=%b ok=%0d, required y=%0d sat=0",
                 k, y, s, ok, exp_y[k]);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [8:0] y;
    logic [1:0] p;
    logic s;
    int n, lat;
    bit ok;
    for (int a = 0; a < 12; a++) write_coef(a, 255);
    for (int k = 0; k < 5; k++) step_out(8'sd127, y, p, s, n, lat, ok);
    for (int k = 0; k < 2; k++) begin
      step_out(8'sd127, y, p, s, n, lat, ok);
      checks++;
      if (!ok || y !== 9'sd255 || s !== 1'b1) begin
        errors++;
        $display("FAIL sat_pos[%0d]: y=%0d sat=%b, required y=255 sat=1", k, y, s);
      end
    end
    for (int k = 0; k < 5; k++) step_out(-8'sd128, y, p, s, n, lat, ok);
    for (int k = 0; k < 2; k++) begin
      step_out(-8'sd128, y, p, s, n, lat, ok);
      checks++;
      if (!ok || y !== 9'(-256) || s !== 1'b1) begin
        errors++;
        $display("FAIL sat_neg[%0d]: y=%0d sat=%b, required y=-256 sat=1", k, y, s);
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    do_reset();
    for (int a = 0; a < 12; a++) write_coef(a, 16);
    x_in = 8'sd64; x_valid = 1; y_ready = 0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (y_valid) begin seen = 1; break; end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_wait: y_valid=0 after 40 cycles, required 1");
    end
    for (int h = 0; h < 5; h++) begin
      checks++;
      if (y_valid !== 1'b1 || x_ready !== 1'b0 || y_out !== 9'sd4 || phase_o !== 2'd0
          || sat_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: y_valid=%b x_ready=%b y=%0d phase=%0d sat=%b, required 1 0 4 0 0",
                 h, y_valid, x_ready, y_out, phase_o, sat_o);
      end
      $display("hold cycle %0d y=%0d phase=%0d", h, y_out, phase_o);
      tick();
    end
    y_ready = 1;
    tick();
    y_ready = 0;
    checks++;
    if (y_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_single: y_valid=%b after one ready cycle, required 0", y_valid);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (y_valid) begin seen = 1; break; end
      tick();
    end
    checks++;
    if (!seen || y_out !== 9'sd8 || phase_o !== 2'd1) begin
      errors++;
      $display("FAIL bp_next: seen=%0d y=%0d phase=%0d, required y=8 phase=1", seen, y_out, phase_o);
    end
    y_ready = 1;
    tick();
    x_valid = 0;
  endtask

  task automatic test_upsampling();
    int exp_y[4] = '{3, 7, 11, 15};
    int ys[4] = '{0, 0, 0, 0};
    int ps[4] = '{0, 0, 0, 0};
    int nout;
    bit done;
    for (int ph = 0; ph < 4; ph++) begin
      write_coef_u(ph * 2, (ph + 1) * 10);
      write_coef_u(ph * 2 + 1, 50);
    end
    x_in_u = 8'sd100; x_valid_u = 1; y_ready_u = 1;
    checks++;
    if (x_ready_u !== 1'b1) begin
      errors++;
      $display("FAIL up_ready_start: x_ready=%b, required 1", x_ready_u);
    end
    tick();
    x_valid_u = 0;
    nout = 0;
    done = 0;
    for (int c = 0; c < 80; c++) begin
      if (x_ready_u) begin done = 1; break; end
      if (y_valid_u) begin
        if (nout < 4) begin
          ys[nout] = int'(y_out_u);
          ps[nout] = int'(phase_u);
        end
        nout++;
        $display("up out y=%0d phase=%0d", y_out_u, phase_u);
      end
      tick();
    end
    checks++;
    if (!done || nout != 4) begin
      errors++;
      $display("FAIL up_count: %0d outputs, ready_seen=%0d, required 4 outputs then ready", nout, done);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ps[k] != k || ys[k] != exp_y[k]) begin
        errors++;
        $display("FAIL up_out[%0d]: phase=%0d y=%0d, required phase=%0d y=%0d",
                 k, ps[k], ys[k], k, exp_y[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic signed [8:0] y;
    logic [1:0] p;
    logic s;
    int n, lat;
    bit ok;
    do_reset();
    for (int a = 0; a < 12; a++) write_coef(a, 16);
    step_out(8'sd64, y, p, s, n, lat, ok);
    checks++;
    if (!ok || y !== 9'sd4 || y_out !== 9'sd4) begin
      errors++;
      $display("FAIL pre_reset_out: y=%0d held=%0d, required 4", y, y_out);
    end
    x_in = 8'sd64; x_valid = 1;
    tick();
    x_valid = 0;
    tick();
    tick();
    reset = 0;
    #1;
    checks++;
    if (y_valid !== 1'b0 || y_out !== 9'sd0 || x_ready !== 1'b1 || phase_o !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: y_valid=%b y=%0d x_ready=%b phase=%0d, required 0 0 1 0",
               y_valid, y_out, x_ready, phase_o);
    end
    tick();
    reset = 1;
    tick();
    step_out(8'sd64, y, p, s, n, lat, ok);
    checks++;
    if (!ok || y !== 9'sd0 || n != 1 || p !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_out: ok=%0d y=%0d inputs=%0d phase=%0d, required y=0 inputs=1 phase=0",
               ok, y, n, p);
    end
  endtask

  initial begin
    test_reset();
    test_phase_sequence();
    test_dc_gain();
    test_saturation();
    test_backpressure();
    test_upsampling();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/rc_poly_resampler.md
Name: rc_poly_resampler

Overview:
Parametrised rational sample-rate converter. It resamples by L/M: upsample by L, downsample by M. It uses a polyphase FIR with N taps per phase, a run-time loadable coefficient bank and one time-multiplexed MAC. Handshaked input and output streams replace fixed enable schedules, so the block supports any L/M ratio and tolerates source stalls and sink backpressure.

Parameters:
W, 8, input sample width (signed)
CW, 9, coefficient width (signed)
OW, 9, output width (signed, saturated)
L, 3, interpolation factor (number of phases), >=1
M, 4, decimation factor, >=1
N, 4, taps per phase, >=2
SHIFT, 8, arithmetic right shift applied to accumulator before saturation
AW, 4, coefficient address width, 2^AW >= L*N

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous active-low reset
x_in  in  W  input sample
x_valid  in  1  x_in valid
x_ready  out  1  block accepts x_in this cycle
y_out  out  OW  output sample
y_valid  out  1  y_out valid
y_ready  in  1  sink accepts y_out
c_we  in  1  coefficient write strobe
c_addr  in  AW  coefficient address = phase*N + tap
c_data  in  CW  coefficient value
phase_o  out  clog2(L) max 1  phase of current/last output
sat_o  out  1  one-cycle pulse, y_out saturated on this output

Behaviour:
- Reset (reset=0, async): state FILL, ph_acc=L, ph=0, delay line taps[0..N-1]=0, coefficients=0, acc=0, y_out=0, y_valid=0, sat_o=0, phase_o=0.
- Delay line: taps[0] is newest. An input is accepted when x_valid & x_ready. Acceptance shifts taps[j]<=taps[j-1] and loads taps[0]<=x_in.
- FILL:
  - If ph_acc>=L: x_ready=1. On acceptance, ph_acc<=ph_acc-L.
  - If ph_acc<L: x_ready=0, ph<=ph_acc, go MAC next cycle.
- MAC: exactly N cycles, j=0..N-1. Cycle j does acc <= (j==0 ? 0 : acc) + coef[ph*N+j]*taps[j]. x_ready=0.
  - Accumulator width W+CW+clog2(N), full precision, no overflow possible.
- OUT: entered the cycle after the last MAC cycle.
  - y_out = sat(acc>>>SHIFT) to OW bits: clamp to [-2^(OW-1), 2^(OW-1)-1].
  - y_valid=1. phase_o=ph. sat_o pulses 1 cycle on OUT entry if clamping occurred.
  - y_out and phase_o hold stable while y_ready=0.
  - On y_valid & y_ready: y_valid<=0, ph_acc<=ph+M, go FILL.
- Inputs consumed per output = floor((ph+M)/L); this may be 0 (upsampling). In that case FILL lasts one cycle with x_ready=0.
- Latency: last input accepted at cycle t gives y_valid at t+N+2 when y_ready is held 1.
- No input is accepted outside FILL. x_ready never depends combinationally on x_valid.
- Coefficient writes are accepted in any state on c_we=1. A write takes effect on the following clock edge and may affect an in-progress MAC. Addresses >= L*N are ignored.
- L=M=1 degenerates to a plain N-tap FIR using phase 0 only.
- Reset asserted mid-MAC or mid-OUT aborts immediately. y_valid drops asynchronously and the coefficient bank clears. After release, the first output needs one new input.

Test Plan:
1. Phase sequence, defaults (L=3, M=4). Stream x_valid=1, y_ready=1. -> phase_o over outputs is 0,1,2,0,1,2. Inputs accepted before each output: 1,1,1,2,1,1,2. Long run gives 3 outputs per 4 inputs.
2. DC gain. Load coef[p*4+j]=16*(p+1), feed constant x=64. After 4 inputs, y_out cycles 16,32,48,16,... with sat_o=0.
3. Saturation. All coefs 255. x=127 constant -> y_out=255 with sat_o pulse (acc 129540, >>>8 = 506). x=-128 -> y_out=-256 with sat_o.
4. Backpressure. Hold y_ready=0 for 5 cycles while in OUT. -> y_out and phase_o stable, y_valid=1, x_ready=0. Release -> exactly one output transferred.
5. Upsampling variant (L=4, M=1, N=2). Single input x=100 with coefs set per phase. -> 4 outputs, phases 0,1,2,3, before the next x_ready=1.
6. Async reset. Pulse reset low during the 2nd MAC cycle. -> y_valid=0 and y_out=0 immediately, coefficients read 0. First post-reset output = 0 after one input.
